// File: rtl/lf_edge_timer_pkg.sv
// Shared constants and types for the LF edge-timing stage.
// Sample and width sizes match the upstream filter and the downstream demod.
package lf_edge_timer_pkg;

    localparam int LF_SAMPLE_W  = 8;
    localparam int LF_WIDTH_W   = 16;
    localparam int LF_DECAY_SH  = 6;
    localparam int LF_MIN_SWING = 16;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_occ_e;

endpackage

// File: rtl/lf_edge_fifo.sv
// Two-entry valid/ready queue for {width, level} records.
// A push into a full queue with no pop is dropped and raises sticky overflow.
module lf_edge_fifo
    import lf_edge_timer_pkg::*;
#(
    parameter int W = LF_WIDTH_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         clr_overflow,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overflow
);

    logic [W-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    fifo_occ_e    occ_r, occ_nxt_s;
    logic         valid_r, overflow_r, drop_s;

    // Next-state of the queue; head is cleared whenever it empties so outputs read 0.
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        occ_nxt_s  = occ_r;
        drop_s     = 1'b0;
        case (occ_r)
            FIFO_EMPTY: begin
                if (push) begin
                    head_nxt_s = din;
                    occ_nxt_s  = FIFO_ONE;
                end else begin
                    occ_nxt_s  = FIFO_EMPTY;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    head_nxt_s = din;
                end else if (push) begin
                    tail_nxt_s = din;
                    occ_nxt_s  = FIFO_FULL;
                end else if (pop) begin
                    head_nxt_s = {W{1'b0}};
                    occ_nxt_s  = FIFO_EMPTY;
                end else begin
                    occ_nxt_s  = FIFO_ONE;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push ? din : {W{1'b0}};
                    occ_nxt_s  = push ? FIFO_FULL : FIFO_ONE;
                end else if (push) begin
                    drop_s     = 1'b1;
                end else begin
                    occ_nxt_s  = FIFO_FULL;
                end
            end
            default: begin
                head_nxt_s = {W{1'b0}};
                tail_nxt_s = {W{1'b0}};
                occ_nxt_s  = FIFO_EMPTY;
            end
        endcase
    end

    // Queue storage, occupancy and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= {W{1'b0}};
            tail_r     <= {W{1'b0}};
            occ_r      <= FIFO_EMPTY;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            occ_r      <= occ_nxt_s;
            valid_r    <= (occ_nxt_s != FIFO_EMPTY);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign valid    = valid_r;
    assign dout     = head_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/lf_edge_timer.sv
// Envelope tracker, self-centring hysteresis slicer and pulse-width timer
// for the filtered LF sample stream; widths are queued for the demod path.
module lf_edge_timer
    import lf_edge_timer_pkg::*;
#(
    parameter int DW        = LF_SAMPLE_W,
    parameter int CW        = LF_WIDTH_W,
    parameter int DECAY_SH  = LF_DECAY_SH,
    parameter int MIN_SWING = LF_MIN_SWING
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] adc_filtered,
    input  logic          data_rdy,
    input  logic          edge_ready,
    input  logic          clr_overflow,
    output logic          edge_valid,
    output logic [CW-1:0] edge_width,
    output logic          edge_level,
    output logic          cur_level,
    output logic          armed,
    output logic          overflow
);

    logic [DW-1:0]       max_r, min_r, max_nxt_s, min_nxt_s;
    logic [DECAY_SH-1:0] dcnt_r, dcnt_nxt_s;
    logic [CW-1:0]       cnt_r, cnt_nxt_s, cnt_inc_s;
    logic                cur_level_r, level_nxt_s, first_r, first_nxt_s;
    logic                armed_r, armed_nxt_s, armed_s, edge_s, push_s, decay_tick_s;
    logic [DW:0]         span_s;
    logic [DW+2:0]       span_ext_s, min_ext_s, s_ext_s, span3_s, hi_s, lo_s;
    logic [CW:0]         fifo_dout_s;

    // Thresholds come from the envelope as registered before this sample.
    assign span_s       = {1'b0, max_r} - {1'b0, min_r};
    assign span_ext_s   = {2'b00, span_s};
    assign min_ext_s    = {3'b000, min_r};
    assign s_ext_s      = {3'b000, adc_filtered};
    assign span3_s      = span_ext_s + (span_ext_s << 1);
    assign hi_s         = min_ext_s + (span3_s >> 2);
    assign lo_s         = min_ext_s + (span_ext_s >> 2);
    assign armed_s      = (span_s >= (DW+1)'(MIN_SWING));
    assign decay_tick_s = &dcnt_r;
    assign cnt_inc_s    = (&cnt_r) ? cnt_r : cnt_r + 1'b1;

    // Per-sample datapath update; everything holds on cycles without a sample.
    always_comb begin
        max_nxt_s   = max_r;
        min_nxt_s   = min_r;
        dcnt_nxt_s  = dcnt_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = cur_level_r;
        first_nxt_s = first_r;
        armed_nxt_s = armed_r;
        edge_s      = 1'b0;
        push_s      = 1'b0;
        if (data_rdy) begin
            dcnt_nxt_s  = dcnt_r + 1'b1;
            armed_nxt_s = armed_s;
            if (adc_filtered > max_r) begin
                max_nxt_s = adc_filtered;
            end else if (decay_tick_s && (max_r > min_r)) begin
                max_nxt_s = max_r - 1'b1;
            end else begin
                max_nxt_s = max_r;
            end
            // Compare against the new max so a 1-LSB gap cannot cross over.
            if (adc_filtered < min_r) begin
                min_nxt_s = adc_filtered;
            end else if (decay_tick_s && (min_r < max_nxt_s)) begin
                min_nxt_s = min_r + 1'b1;
            end else begin
                min_nxt_s = min_r;
            end
            edge_s = armed_s && ((!cur_level_r && (s_ext_s >= hi_s)) ||
                                 ( cur_level_r && (s_ext_s <= lo_s)));
            if (!armed_s) begin
                cnt_nxt_s   = {CW{1'b0}};
                first_nxt_s = 1'b1;
            end else if (edge_s) begin
                cnt_nxt_s   = {CW{1'b0}};
                level_nxt_s = ~cur_level_r;
                first_nxt_s = 1'b0;
                push_s      = ~first_r;
            end else begin
                cnt_nxt_s   = cnt_inc_s;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r       <= {DW{1'b0}};
            min_r       <= {DW{1'b1}};
            dcnt_r      <= {DECAY_SH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            cur_level_r <= 1'b0;
            first_r     <= 1'b1;
            armed_r     <= 1'b0;
        end else begin
            max_r       <= max_nxt_s;
            min_r       <= min_nxt_s;
            dcnt_r      <= dcnt_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cur_level_r <= level_nxt_s;
            first_r     <= first_nxt_s;
            armed_r     <= armed_nxt_s;
        end
    end

    lf_edge_fifo #(.W(CW + 1)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_s),
        .din          ({cnt_inc_s, cur_level_r}),
        .pop          (edge_ready),
        .clr_overflow (clr_overflow),
        .valid        (edge_valid),
        .dout         (fifo_dout_s),
        .overflow     (overflow)
    );

    assign edge_width = fifo_dout_s[CW:1];
    assign edge_level = fifo_dout_s[0];
    assign cur_level  = cur_level_r;
    assign armed      = armed_r;

endmodule
